// File: rtl/reg_cmd_pkg.sv
// Shared definitions for the register-file command master: command opcodes
// and the FSM state encoding.
package reg_cmd_pkg;

  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_CYC,
    RD_ADDR,
    RD_CYC,
    RD_WAIT,
    TX_SEND
  } state_e;

endpackage

// File: rtl/reg_cmd_master.sv
// Bus initiator for the register file. Decodes a byte-serial command stream
// (0xAA addr data = write, 0xBB addr = read) into WrEn/RdEn/Address/WrData
// cycles and hands read results to the serial transmitter.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   RX_P_DATA, RX_D_VLD      received command byte + 1-cycle strobe
//   WrEn, RdEn               register-file write / read enable pulses
//   Address, WrData          register-file address and write data
//   RdData, RdData_Valid     register-file read return
//   TX_P_DATA, TX_D_VLD      byte to transmit + 1-cycle strobe
//   TX_Busy                  transmitter cannot accept a byte
//   Err                      1-cycle pulse: bad address or read timeout
//
// All outputs come straight from registers.
module reg_cmd_master
  import reg_cmd_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [BUS_WIDTH-1:0]  RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [BUS_WIDTH-1:0]  WrData,
  input  logic [BUS_WIDTH-1:0]  RdData,
  input  logic                  RdData_Valid,
  output logic [BUS_WIDTH-1:0]  TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  output logic                  Err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The RdEn cycle plus (CNT_LAST+1) wait cycles puts the Err pulse exactly
  // TIMEOUT cycles after RdEn. Assumes TIMEOUT >= 2.
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 2);
  localparam logic [BUS_WIDTH:0] DEPTH_W  = (BUS_WIDTH + 1)'(DEPTH);
  localparam logic [BUS_WIDTH-1:0] OP_WR  = BUS_WIDTH'(CMD_WR);
  localparam logic [BUS_WIDTH-1:0] OP_RD  = BUS_WIDTH'(CMD_RD);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0]  txd_q, txd_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic                  txv_q, txv_d;
  logic                  err_q, err_d;
  logic                  addr_ok;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      txd_q   <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      txv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txd_q   <= txd_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      txv_q   <= txv_d;
      err_q   <= err_d;
    end
  end

  // Output pulses are computed one state early so that they line up with the
  // registered state: WrEn is high while state_q==WR_CYC, RdEn while RD_CYC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txd_d   = txd_q;
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    txv_d   = 1'b0;
    err_d   = 1'b0;
    addr_ok = ({1'b0, RX_P_DATA} < DEPTH_W);

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == OP_WR)      state_d = WR_ADDR;
          else if (RX_P_DATA == OP_RD) state_d = RD_ADDR;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d = WR_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_d = RX_P_DATA;
          wren_d  = 1'b1;
          state_d = WR_CYC;
        end
      end
      WR_CYC: state_d = IDLE;
      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            rden_d  = 1'b1;
            state_d = RD_CYC;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RD_CYC: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (RdData_Valid) begin
          txd_d   = RdData;
          state_d = TX_SEND;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_SEND: begin
        if (!TX_Busy) begin
          txv_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign TX_P_DATA = txd_q;
  assign TX_D_VLD  = txv_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_reg_cmd_master.sv
module tb_reg_cmd_master;
  import reg_cmd_pkg::*;

  localparam int BW = 8, DEPTH = 8, AW = 4, TO = 16;
  localparam int K_W = 0, K_R = 1, K_ERR = 2, K_TX = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [BW-1:0] RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic          WrEn, RdEn, TX_D_VLD, Err;
  logic [AW-1:0] Address;
  logic [BW-1:0] WrData, RdData, TX_P_DATA;
  logic          RdData_Valid;
  logic          TX_Busy = 1'b0;

  always #5 CLK = ~CLK;

  reg_cmd_master #(.BUS_WIDTH(BW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy), .Err(Err)
  );

  // Register-file environment model: one-cycle read latency.
  logic [7:0] rf [0:15] = '{default: 8'h00};
  logic       rv_q = 1'b0;
  logic [7:0] rd_q = 8'h00;
  logic       rd_kill = 1'b0;
  always @(posedge CLK) begin
    if (WrEn) rf[Address] <= WrData;
    rv_q <= RdEn;
    if (RdEn) rd_q <= rf[Address];
  end
  assign RdData       = rd_q;
  assign RdData_Valid = rv_q & ~rd_kill;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model: expected memory contents and ordered event list.
  typedef struct { int kind; int cyc; int addr; int data; } exp_t;
  exp_t q[$];
  logic [7:0] ref_mem [0:DEPTH-1] = '{default: 8'h00};
  int total = 0, passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic push(input int k, input int c, input int a, input int d);
    exp_t e;
    e.kind = k; e.cyc = c; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input int k, input int a, input int d, input string nm);
    exp_t e;
    if (q.size() == 0) begin
      check({nm, "_unexpected"}, 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    check({nm, "_kind"}, k, e.kind);
    check({nm, "_cycle"}, cyc, e.cyc);
    if (k == K_W || k == K_R) check({nm, "_addr"}, a, e.addr);
    if (k == K_W || k == K_TX) check({nm, "_data"}, d, e.data);
  endtask

  // Monitor: every output event must match the head of the expected list.
  always @(negedge CLK) begin
    if (!RST) begin
      if (WrEn && RdEn) check("wr_rd_exclusive", 32'd1, 32'd0);
      if (WrEn)     pop_cmp(K_W,   int'(Address), int'(WrData), "wr");
      if (RdEn)     pop_cmp(K_R,   int'(Address), 0, "rd");
      if (Err)      pop_cmp(K_ERR, 0, 0, "err");
      if (TX_D_VLD) pop_cmp(K_TX,  0, int'(TX_P_DATA), "tx");
    end
  end

  task automatic strobe(input logic [7:0] b, output int n);
    @(posedge CLK); #1;
    RX_P_DATA = b; RX_D_VLD = 1'b1; n = cyc;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) @(posedge CLK);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge CLK);
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 32'd0);
      q.delete();
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_write(input int a, input logic [7:0] d);
    int n;
    strobe(CMD_WR, n); gap();
    strobe(a[7:0], n);
    if (a >= DEPTH) begin
      push(K_ERR, n + 1, 0, 0);
      // Trailing data byte lands in IDLE and must be ignored as an opcode.
      if (d != CMD_WR && d != CMD_RD) begin gap(); strobe(d, n); end
    end else begin
      gap();
      strobe(d, n);
      push(K_W, n + 1, a, int'(d));
      ref_mem[a] = d;
    end
    drain();
  endtask

  task automatic do_read(input int a, input int hold, input bit kill);
    int n, m;
    rd_kill = kill;
    TX_Busy = (hold > 0);
    strobe(CMD_RD, n); gap();
    strobe(a[7:0], n);
    if (a >= DEPTH) push(K_ERR, n + 1, 0, 0);
    else if (kill) begin
      push(K_R, n + 1, a, 0);
      push(K_ERR, n + 1 + TO, 0, 0);
    end else begin
      push(K_R, n + 1, a, 0);
      if (hold == 0) push(K_TX, n + 4, 0, int'(ref_mem[a]));
      else begin
        for (int i = 0; i < hold; i++) begin
          // A stray write opcode while waiting to transmit must be dropped.
          RX_P_DATA = CMD_WR;
          RX_D_VLD = (cyc == n + 3);
          @(posedge CLK); #1;
        end
        RX_D_VLD = 1'b0;
        TX_Busy = 1'b0;
        m = cyc;
        push(K_TX, (m + 1 > n + 4) ? m + 1 : n + 4, 0, int'(ref_mem[a]));
      end
    end
    drain();
    TX_Busy = 1'b0;
    rd_kill = 1'b0;
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_wren"},  WrEn, 0);
    check({nm, "_rden"},  RdEn, 0);
    check({nm, "_addr"},  Address, 0);
    check({nm, "_wdata"}, WrData, 0);
    check({nm, "_txd"},   TX_P_DATA, 0);
    check({nm, "_txv"},   TX_D_VLD, 0);
    check({nm, "_err"},   Err, 0);
  endtask

  initial begin
    int n, r, a;
    logic [7:0] b;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_outputs_zero("reset");
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) @(posedge CLK); #1;

    // Directed scenarios
    do_write(3, 8'h5C);
    check("mem3", rf[3], 8'h5C);
    do_read(3, 0, 1'b0);
    do_read(3, 5, 1'b0);
    do_write(9, 8'h5C);
    do_read(2, 0, 1'b1);

    strobe(CMD_WR, n);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check_outputs_zero("midrst");
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    do_write(1, 8'h77);
    check("mem1", rf[1], 8'h77);
    do_read(1, 0, 1'b0);

    strobe(8'h12, n); gap();
    do_read(0, 0, 1'b0);

    // Randomized command mix
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      do_write($urandom_range(0, DEPTH - 1), 8'($urandom_range(0, 255)));
      else if (r == 3) do_write($urandom_range(DEPTH, 255), 8'($urandom_range(0, 255)));
      else if (r <= 6) do_read($urandom_range(0, DEPTH - 1), $urandom_range(0, 6), 1'b0);
      else if (r == 7) do_read($urandom_range(DEPTH, 255), 0, 1'b0);
      else if (r == 8) begin
        b = 8'($urandom_range(0, 255));
        if (b == CMD_WR || b == CMD_RD) b = 8'h12;
        strobe(b, n); gap(); drain();
      end else begin
        a = $urandom_range(0, DEPTH - 1);
        do_read(a, 0, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
